hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 24 ++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: stage hazard requests in, register-select
// and PC-freeze controls out.
interface hazard_ctrl_if;
  logic        ld_hazard;
  logic        br_taken;
  logic        mc_start;
  logic        mc_done;
  logic [1:0]  clear_ifid;
  logic [1:0]  clear_idex;
  logic        outI;
  logic        pc_hold;
  logic        mc_err;
  logic [15:0] stall_cnt;

  modport master (
    output ld_hazard, br_taken, mc_start, mc_done,
    input  clear_ifid, clear_idex, outI, pc_hold, mc_err, stall_cnt
  );

  modport slave (
    input  ld_hazard, br_taken, mc_start, mc_done,
    output clear_ifid, clear_idex, outI, pc_hold, mc_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and multi-cycle
// wait sequencing with fully registered (Moore) outputs.
module hazard_ctrl #(
  parameter int FLUSH_CYC  = 2,
  parameter int MC_TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, MCWAIT} state_t;

  localparam logic [2:0] FC = 3'(FLUSH_CYC);
  localparam logic [7:0] MT = 8'(MC_TIMEOUT);

  state_t      r_state, w_next;
  logic [2:0]  r_fcnt, w_fcnt;
  logic [7:0]  r_wcnt, w_wcnt;
  logic        w_err;
  logic [1:0]  r_clear_ifid, r_clear_idex, w_clear_ifid, w_clear_idex;
  logic        r_outI, r_pc_hold, r_mc_err, w_outI, w_pc_hold;
  logic [15:0] r_stall_cnt;

  always_comb begin
    w_next = r_state;
    w_fcnt = r_fcnt;
    w_wcnt = r_wcnt;
    w_err  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (bus.br_taken) begin
          w_next = FLUSH;
          w_fcnt = FC;
        end else if (bus.mc_start) begin
          w_next = MCWAIT;
          w_wcnt = 8'd1;
        end else if (bus.ld_hazard) begin
          w_next = LDSTALL;
        end
      end
      LDSTALL: begin
        if (bus.br_taken) begin
          w_next = FLUSH;
          w_fcnt = FC;
        end else begin
          w_next = RUN;
        end
      end
      FLUSH: begin
        if (bus.br_taken) begin
          w_fcnt = FC;
        end else if (r_fcnt == 3'd1) begin
          w_next = RUN;
        end else begin
          w_fcnt = r_fcnt - 3'd1;
        end
      end
      MCWAIT: begin
        // r_wcnt holds the index of the current wait cycle; done wins a tie with timeout
        if (bus.mc_done) begin
          w_next = RUN;
        end else if (r_wcnt == MT) begin
          w_next = RUN;
          w_err  = 1'b1;
        end else begin
          w_wcnt = r_wcnt + 8'd1;
        end
      end
      default: w_next = RUN;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it
  always_comb begin
    w_clear_ifid = 2'b00;
    w_clear_idex = 2'b00;
    w_outI       = 1'b0;
    w_pc_hold    = 1'b0;
    unique case (w_next)
      LDSTALL: begin
        w_clear_ifid = 2'b10;
        w_clear_idex = 2'b11;
        w_outI       = 1'b1;
        w_pc_hold    = 1'b1;
      end
      FLUSH: begin
        w_clear_ifid = 2'b11;
        w_clear_idex = 2'b11;
      end
      MCWAIT: begin
        w_clear_ifid = 2'b10;
        w_clear_idex = 2'b01;
        w_pc_hold    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_fcnt       <= '0;
      r_wcnt       <= '0;
      r_clear_ifid <= '0;
      r_clear_idex <= '0;
      r_outI       <= 1'b0;
      r_pc_hold    <= 1'b0;
      r_mc_err     <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_fcnt       <= w_fcnt;
      r_wcnt       <= w_wcnt;
      r_clear_ifid <= w_clear_ifid;
      r_clear_idex <= w_clear_idex;
      r_outI       <= w_outI;
      r_pc_hold    <= w_pc_hold;
      r_mc_err     <= w_err;
      if (r_pc_hold && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.clear_ifid = r_clear_ifid;
  assign bus.clear_idex = r_clear_idex;
  assign bus.outI       = r_outI;
  assign bus.pc_hold    = r_pc_hold;
  assign bus.mc_err     = r_mc_err;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-index based reference model.
module tb_hazard_ctrl;

  localparam int FC = 2;
  localparam int MT = 6;

  localparam int M_RUN = 0, M_LD = 1, M_FL = 2, M_MC = 3;

  logic clk = 1'b0;
  logic rst;
  hazard_ctrl_if bus ();

  hazard_ctrl #(.FLUSH_CYC(FC), .MC_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode plus absolute edge indices marking flush end / wait start
  int edge_idx   = 0;
  int mode       = M_RUN;
  int flush_last = 0;
  int mc_entry   = 0;
  int stalls     = 0;
  bit err_exp    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_idx, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ld, input bit br, input bit ms, input bit md);
    edge_idx++;
    err_exp = 1'b0;
    if (r) begin
      mode   = M_RUN;
      stalls = 0;
      return;
    end
    // the cycle that just ended held the PC if it was a stall or a wait
    if ((mode == M_LD || mode == M_MC) && stalls < 65535) stalls++;
    case (mode)
      M_RUN: begin
        if (br)      begin mode = M_FL; flush_last = edge_idx + FC - 1; end
        else if (ms) begin mode = M_MC; mc_entry = edge_idx; end
        else if (ld) mode = M_LD;
      end
      M_LD: begin
        if (br) begin mode = M_FL; flush_last = edge_idx + FC - 1; end
        else mode = M_RUN;
      end
      M_FL: begin
        if (br) flush_last = edge_idx + FC - 1;
        else if (edge_idx > flush_last) mode = M_RUN;
      end
      default: begin
        if (md) mode = M_RUN;
        else if (edge_idx - mc_entry == MT) begin mode = M_RUN; err_exp = 1'b1; end
      end
    endcase
  endtask

  task automatic check_all();
    logic [1:0] e_ifid, e_idex;
    bit e_outI, e_hold;
    case (mode)
      M_LD:    begin e_ifid = 2'b10; e_idex = 2'b11; e_outI = 1; e_hold = 1; end
      M_FL:    begin e_ifid = 2'b11; e_idex = 2'b11; e_outI = 0; e_hold = 0; end
      M_MC:    begin e_ifid = 2'b10; e_idex = 2'b01; e_outI = 0; e_hold = 1; end
      default: begin e_ifid = 2'b00; e_idex = 2'b00; e_outI = 0; e_hold = 0; end
    endcase
    check_val("clear_ifid", 32'(bus.clear_ifid), 32'(e_ifid));
    check_val("clear_idex", 32'(bus.clear_idex), 32'(e_idex));
    check_val("outI",       32'(bus.outI),       32'(e_outI));
    check_val("pc_hold",    32'(bus.pc_hold),    32'(e_hold));
    check_val("mc_err",     32'(bus.mc_err),     32'(err_exp));
    check_val("stall_cnt",  32'(bus.stall_cnt),  32'(stalls));
    check_val("flush_vs_hold", 32'(bus.clear_ifid == 2'b11 && bus.pc_hold), 32'd0);
  endtask

  task automatic step(input bit r, input bit ld, input bit br, input bit ms, input bit md);
    rst           = r;
    bus.ld_hazard = ld;
    bus.br_taken  = br;
    bus.mc_start  = ms;
    bus.mc_done   = md;
    @(posedge clk);
    model_edge(r, ld, br, ms, md);
    #1;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0);
    check_val("reset_stall", 32'(bus.stall_cnt), 32'd0);

    // load-use pulse
    step(0, 1, 0, 0, 0);
    check_val("ld_outI", 32'(bus.outI), 32'd1);
    idle(1);
    check_val("ld_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // single flush, then flush extended by a branch in its first cycle
    step(0, 0, 1, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_val("flush_ext", 32'(bus.clear_idex), 32'd3);
    idle(1);
    check_val("flush_ext_last", 32'(bus.clear_ifid), 32'd3);
    idle(1);
    check_val("flush_ext_done", 32'(bus.clear_ifid), 32'd0);

    // multi-cycle op completing after 5 wait cycles
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(4);
    step(0, 0, 0, 0, 1);
    check_val("mc_done_stall", 32'(bus.stall_cnt), 32'd5);
    check_val("mc_done_noerr", 32'(bus.mc_err), 32'd0);

    // timeout, then done arriving exactly on the timeout cycle
    step(0, 0, 0, 1, 0);
    idle(MT);
    check_val("mc_timeout_err", 32'(bus.mc_err), 32'd1);
    idle(1);
    check_val("mc_err_pulse", 32'(bus.mc_err), 32'd0);
    step(0, 0, 0, 1, 0);
    idle(MT - 1);
    step(0, 0, 0, 0, 1);
    check_val("mc_tie_noerr", 32'(bus.mc_err), 32'd0);

    // everything at once: branch wins
    step(0, 1, 1, 1, 0);
    check_val("prio_flush", 32'(bus.clear_ifid), 32'd3);
    idle(3);

    // start and done together in RUN still enters the wait
    step(0, 0, 0, 1, 1);
    check_val("start_done_hold", 32'(bus.pc_hold), 32'd1);
    step(0, 0, 0, 0, 1);

    // reset on the second wait cycle
    step(0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    check_val("rst_mc_stall", 32'(bus.stall_cnt), 32'd0);
    check_val("rst_mc_hold", 32'(bus.pc_hold), 32'd0);
    idle(MT + 2);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
